// File: rtl/open_file_sequencer_if.sv
// Target-command bus between the open-file sequencer and the APF bridge.
// Latency: none (plain wires); backpressure: bridge paces via ack/done.
// Ports: master drives openfile/id/param_struct, slave returns ack/done/err.
interface open_file_sequencer_if;
  logic        target_dataslot_openfile;
  logic [15:0] target_dataslot_id;
  logic [31:0] target_buffer_param_struct;
  logic        target_dataslot_ack;
  logic        target_dataslot_done;
  logic [2:0]  target_dataslot_err;

  modport master (
    output target_dataslot_openfile,
    output target_dataslot_id,
    output target_buffer_param_struct,
    input  target_dataslot_ack,
    input  target_dataslot_done,
    input  target_dataslot_err
  );

  modport slave (
    input  target_dataslot_openfile,
    input  target_dataslot_id,
    input  target_buffer_param_struct,
    output target_dataslot_ack,
    output target_dataslot_done,
    output target_dataslot_err
  );
endinterface

// File: rtl/open_file_sequencer.sv
// Copies the open-file struct into bridge RAM as big-endian words, then runs the open-file command.
// Latency: STRUCT_BYTES fill cycles + 1 request cycle + bridge ack/done time, then a 1-cycle done pulse.
// Backpressure: none on the struct/RAM side; command side waits on ack/done, bounded by TIMEOUT_CYCLES.
// Ports: clk/reset; start/slot_id request; struct_address/struct_q byte fetch;
//        ram_wr/ram_addr/ram_data word writes; tgt command bus; busy/done/error status.
module open_file_sequencer #(
  parameter int unsigned STRUCT_BYTES       = 264,
  parameter logic [31:0] STRUCT_BRIDGE_ADDR = 32'h0000_0000,
  parameter logic [23:0] TIMEOUT_CYCLES     = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] slot_id,
  output logic [8:0]  struct_address,
  input  logic [7:0]  struct_q,
  output logic        ram_wr,
  output logic [6:0]  ram_addr,
  output logic [31:0] ram_data,
  open_file_sequencer_if.master tgt,
  output logic        busy,
  output logic        done,
  output logic [2:0]  error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL      = 3'd1;
  localparam logic [2:0] S_REQUEST   = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [8:0]  LAST_BYTE = 9'(STRUCT_BYTES - 1);
  localparam logic [23:0] TO_LAST   = TIMEOUT_CYCLES - 24'd1;

  logic [2:0]  state;
  logic [8:0]  byte_idx;
  logic [23:0] tcount;
  logic [23:0] shift;     // previous three struct bytes, oldest in [23:16]
  logic        openfile;
  logic [15:0] id_q;
  logic        timeout;

  assign timeout        = (tcount == TO_LAST);
  assign struct_address = byte_idx;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_FINISH);

  assign tgt.target_dataslot_openfile   = openfile;
  assign tgt.target_dataslot_id         = id_q;
  assign tgt.target_buffer_param_struct = STRUCT_BRIDGE_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= 9'd0;
      tcount   <= 24'd0;
      shift    <= 24'd0;
      ram_wr   <= 1'b0;
      ram_addr <= 7'd0;
      ram_data <= 32'd0;
      openfile <= 1'b0;
      id_q     <= 16'd0;
      error    <= 3'd0;
    end else begin
      ram_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FILL;
            id_q     <= slot_id;
            byte_idx <= 9'd0;
            error    <= 3'd0;
          end
        end

        S_FILL: begin
          shift <= {shift[15:0], struct_q};
          // Fourth byte of a word: emit the whole word including the live byte.
          if (byte_idx[1:0] == 2'd3) begin
            ram_wr   <= 1'b1;
            ram_data <= {shift, struct_q};
            ram_addr <= byte_idx[8:2];
          end
          if (byte_idx == LAST_BYTE) begin
            state <= S_REQUEST;
          end else begin
            byte_idx <= byte_idx + 9'd1;
          end
        end

        // One spare cycle so the last word write lands before the command.
        S_REQUEST: begin
          openfile <= 1'b1;
          tcount   <= 24'd0;
          state    <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          tcount <= tcount + 24'd1;
          if (tgt.target_dataslot_ack) begin
            openfile <= 1'b0;
            // ack and done together count as ack followed by done.
            if (tgt.target_dataslot_done) begin
              error <= tgt.target_dataslot_err;
              state <= S_FINISH;
            end else begin
              state <= S_WAIT_DONE;
            end
          end else if (timeout) begin
            openfile <= 1'b0;
            error    <= 3'h7;
            state    <= S_FINISH;
          end
        end

        S_WAIT_DONE: begin
          tcount <= tcount + 24'd1;
          // A done coinciding with the timeout wins and reports its own result.
          if (tgt.target_dataslot_done) begin
            error <= tgt.target_dataslot_err;
            state <= S_FINISH;
          end else if (timeout) begin
            error <= 3'h7;
            state <= S_FINISH;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_open_file_sequencer.sv
// Self-checking bench for open_file_sequencer: scheduled bridge responses, timeline model.
// Latency: n/a; backpressure: bridge ack/done driven from a per-scenario schedule.
// Ports: none.
module tb_open_file_sequencer;
  localparam int NB = 264;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] slot_id;
  logic [8:0]  struct_address;
  logic [7:0]  struct_q;
  logic        ram_wr;
  logic [6:0]  ram_addr;
  logic [31:0] ram_data;
  logic        busy;
  logic        done;
  logic [2:0]  error;

  logic [7:0]  mem [512];

  open_file_sequencer_if tgt_if();

  open_file_sequencer #(
    .STRUCT_BYTES(NB),
    .STRUCT_BRIDGE_ADDR(32'h0000_0000),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .slot_id(slot_id),
    .struct_address(struct_address),
    .struct_q(struct_q),
    .ram_wr(ram_wr),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .tgt(tgt_if),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  assign struct_q = mem[struct_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Scenario timeline: edge indices at which events are sampled / take effect.
  int s_start, s_op, s_fall, s_fin, s_rst, s_ack, s_ack2, s_dn, s_x, end_c;
  logic [2:0]  s_err, s_res, prev_err;
  logic [15:0] s_id, x_id, prev_id;
  int wr_cnt, of_cnt, done_cnt;
  logic [31:0] got_w [66];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]};
  endfunction

  task automatic check_cycle();
    int c = cyc;
    bit in_rst;
    bit e_busy, e_open, e_done, e_wr;
    logic [2:0] e_err;
    logic [15:0] e_id;
    int rel;
    in_rst = (s_rst != 0) && (c >= s_rst);
    rel    = c - s_start - 4;
    e_busy = !in_rst && c >= s_start && c <= s_fin;
    e_open = !in_rst && c >= s_op && c < s_fall;
    e_done = !in_rst && c == s_fin;
    e_err  = in_rst ? 3'd0 : (c < s_start ? prev_err : (c < s_fin ? 3'd0 : s_res));
    e_id   = in_rst ? 16'd0 : (c < s_start ? prev_id : s_id);
    e_wr   = !in_rst && rel >= 0 && rel <= 4*65 && (rel % 4) == 0;
    chk("busy", busy, e_busy);
    chk("openfile", tgt_if.target_dataslot_openfile, e_open);
    chk("done", done, e_done);
    chk("error", error, e_err);
    chk("slot_id_out", tgt_if.target_dataslot_id, e_id);
    chk("param_struct", tgt_if.target_buffer_param_struct, 32'h0);
    chk("ram_wr", ram_wr, e_wr);
    if (e_wr) begin
      chk("ram_addr", ram_addr, rel / 4);
      chk("ram_data", ram_data, word(rel / 4));
    end
    if (in_rst) chk("struct_addr_rst", struct_address, 0);
    if (ram_wr === 1'b1) begin
      wr_cnt++;
      if (ram_addr < 7'd66) got_w[ram_addr] = ram_data;
    end
    if (tgt_if.target_dataslot_openfile === 1'b1) of_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic drive_next();
    int n = cyc + 1;
    start   = (n == s_start) || (n == s_x);
    slot_id = (n == s_start) ? s_id : ((n == s_x) ? x_id : 16'($urandom));
    reset   = (s_rst != 0) && n >= s_rst && n < s_rst + 3;
    tgt_if.target_dataslot_ack  = (n == s_ack) || (n == s_ack2);
    tgt_if.target_dataslot_done = (n == s_dn);
    tgt_if.target_dataslot_err  = (n == s_dn) ? s_err : 3'($urandom);
  endtask

  // a/a2/d are offsets from the openfile rising edge (0 = never); r/x from start.
  task automatic run(input int a, input int a2, input int d, input logic [2:0] err,
                     input int r, input int x, input logic [15:0] id, input logic [15:0] xid);
    int t_to;
    s_start = cyc + 2;
    s_op    = s_start + NB + 1;
    t_to    = s_op + TO;
    s_ack   = (a != 0) ? s_op + a : 0;
    s_ack2  = (a2 != 0) ? s_op + a2 : 0;
    s_dn    = (d != 0) ? s_op + d : 0;
    s_rst   = (r != 0) ? s_start + r : 0;
    s_x     = (x != 0) ? s_start + x : 0;
    s_err   = err;
    s_id    = id;
    x_id    = xid;
    if (s_ack != 0 && (s_ack < t_to || (s_ack == t_to && s_dn == s_ack))) begin
      s_fall = s_ack;
      if (s_dn != 0 && s_dn >= s_ack && s_dn <= t_to) begin
        s_fin = s_dn;
        s_res = err;
      end else begin
        s_fin = t_to;
        s_res = 3'h7;
      end
    end else begin
      s_fall = t_to;
      s_fin  = t_to;
      s_res  = 3'h7;
    end
    if (s_rst != 0) begin
      s_fin = 1 << 30;
      end_c = s_rst + 5;
    end else begin
      end_c = s_fin + 3;
    end
    wr_cnt = 0;
    of_cnt = 0;
    done_cnt = 0;
    while (cyc < end_c) begin
      @(negedge clk);
      check_cycle();
      drive_next();
    end
    prev_err = (s_rst != 0) ? 3'd0 : s_res;
    prev_id  = (s_rst != 0) ? 16'd0 : s_id;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] path [12];
    int a, d;
    path = '{8'h2F, 8'h53, 8'h61, 8'h76, 8'h65, 8'h73, 8'h2F, 8'h61, 8'h2E, 8'h73, 8'h61, 8'h76};
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    s_start = 1 << 30; s_op = 1 << 30; s_fall = 0; s_fin = 1 << 30;
    s_rst = 0; s_ack = 0; s_ack2 = 0; s_dn = 0; s_x = 0;
    prev_err = 3'd0; prev_id = 16'd0;
    reset = 1'b1; start = 1'b0; slot_id = 16'd0;
    tgt_if.target_dataslot_ack = 1'b0;
    tgt_if.target_dataslot_done = 1'b0;
    tgt_if.target_dataslot_err = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_openfile", tgt_if.target_dataslot_openfile, 0);
    chk("rst_id", tgt_if.target_dataslot_id, 0);
    chk("rst_struct_addr", struct_address, 0);
    chk("rst_param", tgt_if.target_buffer_param_struct, 32'h0);
    reset = 1'b0;

    // Known struct: "/Saves/a.sav", flags 3, size 0x00012000.
    for (int i = 0; i < 12; i++) mem[i] = path[i];
    mem[259] = 8'h03;
    mem[260] = 8'h00; mem[261] = 8'h01; mem[262] = 8'h20; mem[263] = 8'h00;
    run(5, 0, 25, 3'd0, 0, 0, 16'h1234, 16'h0);
    chk("word0", got_w[0], 32'h2F536176);
    chk("word64", got_w[64], 32'h00000003);
    chk("word65", got_w[65], 32'h00012000);
    chk("writes_known", wr_cnt, 66);
    chk("openfile_cycles", of_cnt, 5);
    chk("done_pulses", done_cnt, 1);
    chk("model_latency", s_fin - s_start, 290);
    chk("error_ok", error, 3'd0);
    chk("busy_idle", busy, 0);

    // err=2 result, with a stray second ack in WAIT_DONE.
    rand_mem();
    a = 1 + int'($urandom_range(0, 9));
    run(a, a + 2, a + 5 + int'($urandom_range(0, 20)), 3'd2, 0, 0, 16'($urandom), 16'h0);
    chk("error_held", error, 3'd2);
    chk("done_pulses_e2", done_cnt, 1);

    // No ack: timeout, plus an ignored start at FILL byte 50.
    rand_mem();
    run(0, 0, 0, 3'd0, 0, 51, 16'hBEEF, 16'h5A5A);
    chk("timeout_openfile_cycles", of_cnt, TO);
    chk("timeout_error", error, 3'h7);
    chk("timeout_writes", wr_cnt, 66);
    chk("timeout_done_pulses", done_cnt, 1);

    // Reset at FILL byte 130 aborts the run.
    rand_mem();
    run(5, 0, 25, 3'd1, 131, 0, 16'hCAFE, 16'h0);
    chk("abort_writes", wr_cnt, 32);
    chk("abort_done_pulses", done_cnt, 0);
    chk("abort_openfile", of_cnt, 0);

    // Clean restart; ack and done in the same cycle.
    rand_mem();
    run(3, 0, 3, 3'd4, 0, 0, 16'($urandom), 16'h0);
    chk("same_cycle_writes", wr_cnt, 66);
    chk("same_cycle_error", error, 3'd4);

    // done coinciding with the timeout wins.
    rand_mem();
    run(2, 0, TO, 3'd5, 0, 0, 16'($urandom), 16'h0);
    chk("done_vs_timeout", error, 3'd5);

    // ack but no done: timeout in WAIT_DONE.
    rand_mem();
    run(3, 0, 0, 3'd0, 0, 0, 16'($urandom), 16'h0);
    chk("wait_done_timeout", error, 3'h7);

    for (int i = 0; i < 4; i++) begin
      rand_mem();
      a = 1 + int'($urandom_range(0, 40));
      d = a + int'($urandom_range(0, 40));
      run(a, 0, d, 3'($urandom_range(0, 6)), 0, int'($urandom_range(0, 1)) * 100,
          16'($urandom), 16'($urandom));
      chk("rand_writes", wr_cnt, 66);
      chk("rand_done_pulses", done_cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
